// File: rtl/dccm_arbiter.sv
// DCCM arbiter: fixed core priority with optional DMA starvation guard.
// Build with DCCM_ARB_STARVE_EN defined to enable the forced DMA grant.
module dccm_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            c_req_valid,
  output logic            c_req_ready,
  input  logic            c_req_we,
  input  logic [DW/8-1:0] c_req_wstrb,
  input  logic [AW-1:0]   c_req_addr,
  input  logic [DW-1:0]   c_req_wdata,
  output logic            c_rsp_valid,
  output logic [DW-1:0]   c_rsp_rdata,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic            d_req_we,
  input  logic [DW/8-1:0] d_req_wstrb,
  input  logic [AW-1:0]   d_req_addr,
  input  logic [DW-1:0]   d_req_wdata,
  output logic            d_rsp_valid,
  output logic [DW-1:0]   d_rsp_rdata,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [DW/8-1:0] ram_wstrb,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic gnt_c;
  logic gnt_d;
  logic force_d;
  logic pend_c;
  logic pend_d;

`ifdef DCCM_ARB_STARVE_EN
  logic [CW-1:0] wait_cnt;

  assign force_d = (wait_cnt == CW'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (gnt_d || !d_req_valid) begin
      wait_cnt <= '0;
    end else if (gnt_c && !force_d) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign force_d = 1'b0;
`endif

  // No SRAM access is granted while reset is asserted.
  assign gnt_d = rst_n & d_req_valid
               & (~c_req_valid | force_d);
  assign gnt_c = rst_n & c_req_valid & ~gnt_d;

  assign c_req_ready = gnt_c;
  assign d_req_ready = gnt_d;

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_wstrb = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      gnt_c: begin
        ram_cs    = 1'b1;
        ram_we    = c_req_we;
        ram_wstrb = c_req_we ? c_req_wstrb : '0;
        ram_addr  = c_req_addr;
        ram_wdata = c_req_wdata;
      end
      gnt_d: begin
        ram_cs    = 1'b1;
        ram_we    = d_req_we;
        ram_wstrb = d_req_we ? d_req_wstrb : '0;
        ram_addr  = d_req_addr;
        ram_wdata = d_req_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_c <= 1'b0;
      pend_d <= 1'b0;
    end else begin
      pend_c <= gnt_c & ~c_req_we;
      pend_d <= gnt_d & ~d_req_we;
    end
  end

  assign c_rsp_valid = pend_c;
  assign d_rsp_valid = pend_d;
  assign c_rsp_rdata = pend_c ? ram_rdata : '0;
  assign d_rsp_rdata = pend_d ? ram_rdata : '0;

endmodule

// File: tb/tb_dccm_arbiter.sv
// Directed bench for dccm_arbiter with a behavioural byte-strobed SRAM.
// Starvation expectations follow DCCM_ARB_STARVE_EN.
module tb_dccm_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req_valid, c_req_ready, c_req_we;
  logic [3:0]    c_req_wstrb;
  logic [AW-1:0] c_req_addr;
  logic [DW-1:0] c_req_wdata;
  logic          c_rsp_valid;
  logic [DW-1:0] c_rsp_rdata;
  logic          d_req_valid, d_req_ready, d_req_we;
  logic [3:0]    d_req_wstrb;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_rdata;
  logic          ram_cs, ram_we;
  logic [3:0]    ram_wstrb;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  bit starve;

  always #5 clk = ~clk;

  dccm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
    .c_req_we(c_req_we), .c_req_wstrb(c_req_wstrb),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_wstrb(ram_wstrb),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    c_req_valid = 0; c_req_we = 0; c_req_wstrb = 0;
    c_req_addr = 0; c_req_wdata = 0;
    d_req_valid = 0; d_req_we = 0; d_req_wstrb = 0;
    d_req_addr = 0; d_req_wdata = 0;
  endtask

  task automatic setc(input logic v, input logic we,
                      input logic [3:0] s, input logic [AW-1:0] a,
                      input logic [DW-1:0] w);
    c_req_valid = v; c_req_we = we; c_req_wstrb = s;
    c_req_addr = a; c_req_wdata = w;
  endtask

  task automatic setd(input logic v, input logic we,
                      input logic [3:0] s, input logic [AW-1:0] a,
                      input logic [DW-1:0] w);
    d_req_valid = v; d_req_we = we; d_req_wstrb = s;
    d_req_addr = a; d_req_wdata = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dwrite(input logic [AW-1:0] a, input logic [DW-1:0] w);
    setd(1, 1, 4'hF, a, w);
    #1;
    check("pre_rdy", d_req_ready, 1);
    step();
    idle();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rdy"}, {c_req_ready, d_req_ready}, 0);
    check({tag, "_rspv"}, {c_rsp_valid, d_rsp_valid}, 0);
    check({tag, "_rdata"}, {c_rsp_rdata, d_rsp_rdata}, 0);
    check({tag, "_ram"}, {ram_cs, ram_we, ram_wstrb, ram_addr}, 0);
    check({tag, "_wdata"}, ram_wdata, 0);
  endtask

  initial begin
`ifdef DCCM_ARB_STARVE_EN
    starve = 1;
`else
    starve = 0;
`endif
    idle();
    step();
    step();
    check_quiet("reset");
    rst_n = 1;
    step();

    dwrite(14'h10, 32'hDEADBEEF);
    dwrite(14'h20, 32'h11223344);
    dwrite(14'h4,  32'h44444444);
    step();

    // single core read
    setc(1, 0, 0, 14'h10, 0);
    #1;
    check("t1_rdy", {c_req_ready, d_req_ready}, 2'b10);
    check("t1_ram", {ram_cs, ram_we, ram_wstrb, ram_addr}, {2'b10, 4'h0, 14'h10});
    step();
    idle();
    #1;
    check("t1_rspv", {c_rsp_valid, d_rsp_valid}, 2'b10);
    check("t1_rdata", c_rsp_rdata, 32'hDEADBEEF);
    check("t1_drdata", d_rsp_rdata, 0);
    step();
    check("t1_pulse", c_rsp_valid, 0);

    // simultaneous core read and DMA write
    setc(1, 0, 0, 14'h4, 0);
    setd(1, 1, 4'hF, 14'h8, 32'h12345678);
    #1;
    check("t2_c0", {c_req_ready, d_req_ready}, 2'b10);
    step();
    setc(0, 0, 0, 0, 0);
    #1;
    check("t2_d1", {c_req_ready, d_req_ready}, 2'b01);
    check("t2_ram", {ram_cs, ram_we, ram_wstrb, ram_addr}, {2'b11, 4'hF, 14'h8});
    check("t2_wdata", ram_wdata, 32'h12345678);
    check("t2_crsp", {c_rsp_valid, c_rsp_rdata}, {1'b1, 32'h44444444});
    step();
    setd(1, 0, 4'hF, 14'h8, 0);
    #1;
    check("t2_drd", {d_req_ready, ram_wstrb}, {1'b1, 4'h0});
    step();
    idle();
    #1;
    check("t2_drsp", {d_rsp_valid, d_rsp_rdata}, {1'b1, 32'h12345678});
    check("t2_nocross", {c_rsp_valid, c_rsp_rdata}, 0);

    // partial write then readback
    setc(1, 1, 4'h3, 14'h20, 32'hAABBCCDD);
    #1;
    check("t3_wr", {ram_we, ram_wstrb, ram_wdata}, {1'b1, 4'h3, 32'hAABBCCDD});
    step();
    setc(1, 0, 0, 14'h20, 0);
    step();
    idle();
    #1;
    check("t3_rd", {c_rsp_valid, c_rsp_rdata}, {1'b1, 32'h1122CCDD});
    step();

    // both ports valid for 15 cycles
    for (int i = 0; i < 15; i++) begin
      logic expd;
      setc(1, 0, 0, AW'(14'h100 + i), 0);
      setd(1, 0, 0, AW'(14'h200 + i), 0);
      #1;
      expd = starve && (i % (MW + 1) == MW);
      check($sformatf("starve_%0d", i), {c_req_ready, d_req_ready}, {~expd, expd});
      step();
    end
    idle();
    step();
    step();

    // alternating owners
    setc(1, 0, 0, 14'h10, 0);
    step();
    setc(0, 0, 0, 0, 0);
    setd(1, 0, 0, 14'h4, 0);
    #1;
    check("alt_c0", {c_rsp_valid, c_rsp_rdata}, {1'b1, 32'hDEADBEEF});
    check("alt_d0", {d_rsp_valid, d_rsp_rdata}, 0);
    step();
    setd(0, 0, 0, 0, 0);
    setc(1, 0, 0, 14'h20, 0);
    #1;
    check("alt_d1", {d_rsp_valid, d_rsp_rdata}, {1'b1, 32'h44444444});
    check("alt_c1", {c_rsp_valid, c_rsp_rdata}, 0);
    step();
    idle();
    #1;
    check("alt_c2", {c_rsp_valid, c_rsp_rdata}, {1'b1, 32'h1122CCDD});
    check("alt_d2", d_rsp_valid, 0);
    step();

    // reset between acceptance and response
    setc(1, 0, 0, 14'h10, 0);
    @(posedge clk);
    #1;
    idle();
    rst_n = 0;
    #1;
    check("rst_mid", c_rsp_valid, 0);
    step();
    rst_n = 1;
    step();
    check_quiet("post1");
    step();
    check_quiet("post2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
